// File: rtl/wb_arb_pkg.sv
// Shared select codes, FSM state type and starvation limit for the write-port arbiter.
package wb_arb_pkg;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b10;
    localparam logic [1:0] SEL_D2 = 2'b01;

    localparam int STARVE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        LOCK
    } arb_state_t;

    // Source index to mux select code; 11 is never produced.
    function automatic logic [1:0] sel_code(input logic [1:0] idx);
        case (idx)
            2'd1:    sel_code = SEL_D1;
            2'd2:    sel_code = SEL_D2;
            default: sel_code = SEL_D0;
        endcase
    endfunction

    // Round-robin successor over the three sources.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        rr_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/wb_sel_mux3.sv
// Combinational 3-way data select driven by the package select codes.
module wb_sel_mux3
    import wb_arb_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            SEL_D1:  y = d1;
            SEL_D2:  y = d2;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter with optional lock and a one-entry registered output for the RF write port.
// Optional starvation monitor (starve port, forced lock release) enabled by WBARB_STARVE_MON_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NREQ  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [WIDTH-1:0]  d0,
    input  logic [WIDTH-1:0]  d1,
    input  logic [WIDTH-1:0]  d2,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        sel,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        out_src,
`ifdef WBARB_STARVE_MON_EN
    output logic [NREQ-1:0]   starve,
`endif
    input  logic              out_ready
);

    arb_state_t       state, nstate;
    logic [1:0]       owner, nowner;
    logic [1:0]       rr_ptr;
    logic [1:0]       win;
    logic             has_win, locked, can_accept, accept, ov_nxt, force_rel;
    logic [WIDTH-1:0] mux_y;

    assign can_accept = !out_valid || out_ready;
    assign locked     = (state == LOCK) && req[owner];

    always_comb begin
        logic [1:0] idx;
        has_win = 1'b0;
        win     = 2'd0;
        idx     = rr_next(rr_ptr);
        if (locked) begin
            has_win = 1'b1;
            win     = owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!has_win && req[idx]) begin
                    has_win = 1'b1;
                    win     = idx;
                end
                idx = rr_next(idx);
            end
        end
    end

    // Outputs forced to their reset values while reset is held.
    always_comb begin
        gnt = '0;
        sel = SEL_D0;
        if (has_win && !reset) begin
            sel = sel_code(win);
            if (can_accept)
                gnt[win] = 1'b1;
        end
    end

    assign accept = |gnt;
    assign ov_nxt = accept || (out_valid && !out_ready);

    wb_sel_mux3 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .y   (mux_y)
    );

`ifdef WBARB_STARVE_MON_EN
    logic [3:0] wcnt [NREQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++)
                wcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i])
                    wcnt[i] <= '0;
                else if (req[i] && wcnt[i] != 4'(STARVE_MAX))
                    wcnt[i] <= wcnt[i] + 4'd1;
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < NREQ; i++)
            starve[i] = (wcnt[i] == 4'(STARVE_MAX));
    end

    assign force_rel = |(starve & ~(NREQ'(1) << owner));
`else
    assign force_rel = 1'b0;
`endif

    // A held lock survives stalls; any unlocked cycle falls back to the generic rule.
    always_comb begin
        nstate = state;
        nowner = owner;
        if (locked) begin
            if (accept)
                nstate = (lock[owner] && !force_rel) ? LOCK : BUSY;
        end else if (accept && lock[win]) begin
            nstate = LOCK;
            nowner = win;
        end else begin
            nstate = ov_nxt ? BUSY : IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 2'd0;
            rr_ptr    <= 2'd2;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else begin
            state     <= nstate;
            owner     <= nowner;
            out_valid <= ov_nxt;
            if (accept) begin
                out_data <= mux_y;
                out_src  <= win;
                rr_ptr   <= win;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter plus reset-in-lock and starvation sequences.
module tb_wb_port_arbiter;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   req, lock;
    logic [W-1:0] d0, d1, d2;
    logic [2:0]   gnt;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;
`ifdef WBARB_STARVE_MON_EN
    logic [2:0]   starve;
`endif

    wb_port_arbiter #(.WIDTH(W), .NREQ(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef WBARB_STARVE_MON_EN
        .starve    (starve),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   req;
        logic [2:0]   lock;
        logic         rdy;
        logic [W-1:0] d0, d1, d2;
        logic [2:0]   gnt;
        logic [1:0]   sel;
        logic         ov;
        logic [W-1:0] data;
        logic [1:0]   src;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    int n_total = 0;
    int n_pass  = 0;

    function automatic vec_t mk(logic [2:0] rq, logic [2:0] lk, logic rd,
                                logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                                logic [2:0] g, logic [1:0] s, logic v,
                                logic [W-1:0] dt, logic [1:0] sr);
        vec_t t;
        t.req = rq; t.lock = lk; t.rdy = rd; t.d0 = a; t.d1 = b; t.d2 = c;
        t.gnt = g; t.sel = s; t.ov = v; t.data = dt; t.src = sr;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    endtask

    task automatic chk_regs(input int idx, input logic v, input logic [W-1:0] dt, input logic [1:0] sr);
        chk("out_valid", idx, 32'(out_valid), 32'(v));
        chk("out_data",  idx, 32'(out_data),  32'(dt));
        chk("out_src",   idx, 32'(out_src),   32'(sr));
    endtask

    initial begin
        // Rows: req lock rdy d0 d1 d2 | gnt sel ov data src (registered columns show prior edges)
        tv[0]  = mk(3'b111, 3'b000, 1, 9'h011, 9'h1A5, 9'h0C2, 3'b001, 2'b00, 0, 9'h000, 2'd0);
        tv[1]  = mk(3'b111, 3'b000, 1, 9'h011, 9'h1A5, 9'h0C2, 3'b010, 2'b10, 1, 9'h011, 2'd0);
        tv[2]  = mk(3'b111, 3'b000, 1, 9'h011, 9'h1A5, 9'h0C2, 3'b100, 2'b01, 1, 9'h1A5, 2'd1);
        tv[3]  = mk(3'b111, 3'b000, 1, 9'h011, 9'h1A5, 9'h0C2, 3'b001, 2'b00, 1, 9'h0C2, 2'd2);
        tv[4]  = mk(3'b000, 3'b000, 1, 9'h011, 9'h1A5, 9'h0C2, 3'b000, 2'b00, 1, 9'h011, 2'd0);
        tv[5]  = mk(3'b010, 3'b000, 0, 9'h011, 9'h1A5, 9'h0C2, 3'b010, 2'b10, 0, 9'h011, 2'd0);
        tv[6]  = mk(3'b010, 3'b000, 0, 9'h011, 9'h1A5, 9'h0C2, 3'b000, 2'b10, 1, 9'h1A5, 2'd1);
        tv[7]  = mk(3'b010, 3'b000, 0, 9'h011, 9'h1A5, 9'h0C2, 3'b000, 2'b10, 1, 9'h1A5, 2'd1);
        tv[8]  = mk(3'b010, 3'b000, 0, 9'h011, 9'h1A5, 9'h0C2, 3'b000, 2'b10, 1, 9'h1A5, 2'd1);
        tv[9]  = mk(3'b010, 3'b000, 1, 9'h011, 9'h05A, 9'h0C2, 3'b010, 2'b10, 1, 9'h1A5, 2'd1);
        tv[10] = mk(3'b100, 3'b000, 1, 9'h011, 9'h05A, 9'h0C2, 3'b100, 2'b01, 1, 9'h05A, 2'd1);
        tv[11] = mk(3'b000, 3'b000, 1, 9'h011, 9'h05A, 9'h0C2, 3'b000, 2'b00, 1, 9'h0C2, 2'd2);
        tv[12] = mk(3'b000, 3'b000, 1, 9'h011, 9'h05A, 9'h0C2, 3'b000, 2'b00, 0, 9'h0C2, 2'd2);
        tv[13] = mk(3'b011, 3'b001, 1, 9'h033, 9'h05A, 9'h0C2, 3'b001, 2'b00, 0, 9'h0C2, 2'd2);
        tv[14] = mk(3'b011, 3'b001, 1, 9'h033, 9'h05A, 9'h0C2, 3'b001, 2'b00, 1, 9'h033, 2'd0);
        tv[15] = mk(3'b011, 3'b001, 1, 9'h033, 9'h05A, 9'h0C2, 3'b001, 2'b00, 1, 9'h033, 2'd0);
        tv[16] = mk(3'b011, 3'b000, 1, 9'h033, 9'h05A, 9'h0C2, 3'b001, 2'b00, 1, 9'h033, 2'd0);
        tv[17] = mk(3'b011, 3'b000, 1, 9'h033, 9'h05A, 9'h0C2, 3'b010, 2'b10, 1, 9'h033, 2'd0);
        tv[18] = mk(3'b000, 3'b000, 1, 9'h033, 9'h05A, 9'h0C2, 3'b000, 2'b00, 1, 9'h05A, 2'd1);
        tv[19] = mk(3'b001, 3'b110, 1, 9'h033, 9'h05A, 9'h0C2, 3'b001, 2'b00, 0, 9'h05A, 2'd1);
        tv[20] = mk(3'b011, 3'b000, 1, 9'h033, 9'h05A, 9'h0C2, 3'b010, 2'b10, 1, 9'h033, 2'd0);
        tv[21] = mk(3'b000, 3'b000, 1, 9'h033, 9'h05A, 9'h0C2, 3'b000, 2'b00, 1, 9'h05A, 2'd1);

        reset = 1'b1; req = '0; lock = '0; out_ready = 1'b1;
        d0 = 9'h011; d1 = 9'h1A5; d2 = 9'h0C2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 0, 32'(gnt), 32'd0);
        chk("rst_sel", 0, 32'(sel), 32'd0);
        chk_regs(-1, 1'b0, 9'h000, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req = tv[i].req; lock = tv[i].lock; out_ready = tv[i].rdy;
            d0 = tv[i].d0; d1 = tv[i].d1; d2 = tv[i].d2;
            #1;
            chk("gnt", i, 32'(gnt), 32'(tv[i].gnt));
            chk("sel", i, 32'(sel), 32'(tv[i].sel));
            chk_regs(i, tv[i].ov, tv[i].data, tv[i].src);
        end

        // Reset asserted while locked with a word held: everything clears at once.
        @(negedge clk);
        req = 3'b001; lock = 3'b001; out_ready = 1'b1; d0 = 9'h0F0;
        @(negedge clk);
        #1;
        chk("lock_pre_ov", 100, 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstlk_gnt", 101, 32'(gnt), 32'd0);
        chk("rstlk_sel", 101, 32'(sel), 32'd0);
        chk_regs(101, 1'b0, 9'h000, 2'd0);
        @(negedge clk);
        reset = 1'b0; req = 3'b111; lock = 3'b000;
        #1;
        chk("post_rst_gnt", 102, 32'(gnt), 32'b001);
        chk("post_rst_ov",  102, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_gnt", 103, 32'(gnt), 32'b010);
        chk_regs(103, 1'b1, 9'h0F0, 2'd0);

`ifdef WBARB_STARVE_MON_EN
        // Source 0 locks while source 2 waits; at 15 waits the lock is broken.
        @(negedge clk);
        reset = 1'b1; req = '0; lock = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req = 3'b101; lock = 3'b001; out_ready = 1'b1;
            #1;
            chk("stv_gnt",    200 + k, 32'(gnt),    32'b001);
            chk("stv_starve", 200 + k, 32'(starve), (k >= 15) ? 32'b100 : 32'b000);
        end
        @(negedge clk);
        #1;
        chk("stv_release_gnt", 216, 32'(gnt), 32'b100);
        @(negedge clk);
        #1;
        chk("stv_clear", 217, 32'(starve), 32'b000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
